// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: one outstanding load/store on a req/gnt/rvalid bus.
// It builds byte enables and lane-replicated store data, traps misaligned or
// unsupported accesses without touching the bus, and aborts on a response timeout.
module data_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_resp_valid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic [1:0]  core_err_cause,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    localparam logic [1:0]       CauseNone   = 2'b00;
    localparam logic [1:0]       CauseLdMis  = 2'b01;
    localparam logic [1:0]       CauseStMis  = 2'b10;
    localparam logic [1:0]       CauseTmo    = 2'b11;
    localparam logic [CNT_W-1:0] CntLast     = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic        f3_ok;
    logic        misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    assign core_req_ready = (state_q == IDLE);

    // Decode the incoming request: legality, alignment, byte lanes and store data.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = 32'h0;
        if (core_we) begin
            f3_ok = ~core_funct3[2] & (core_funct3[1:0] != 2'b11);
        end else begin
            f3_ok = (core_funct3[1:0] != 2'b11) & ~(core_funct3[2] & core_funct3[1]);
        end
        misaligned = ~f3_ok
                   | ((core_funct3[1:0] == 2'b01) & core_addr[0])
                   | ((core_funct3[1:0] == 2'b10) & (core_addr[1:0] != 2'b00));
        if (core_we) begin
            case (core_funct3[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << core_addr[1:0];
                    wdata_c = {4{core_wdata[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << core_addr[1:0];
                    wdata_c = {2{core_wdata[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = core_wdata;
                end
            endcase
        end
    end

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_be          <= 4'b0000;
            mem_addr        <= 32'h0;
            mem_wdata       <= 32'h0;
            core_resp_valid <= 1'b0;
            core_rdata      <= 32'h0;
            core_err        <= 1'b0;
            core_err_cause  <= CauseNone;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core_req_valid) begin
                        if (misaligned) begin
                            core_resp_valid <= 1'b1;
                            core_rdata      <= 32'h0;
                            core_err        <= 1'b1;
                            core_err_cause  <= core_we ? CauseStMis : CauseLdMis;
                            state_q         <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_addr  <= {core_addr[31:2], 2'b00};
                            mem_we    <= core_we;
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                            state_q   <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt_q   <= '0;
                        if (mem_rvalid) begin
                            core_resp_valid <= 1'b1;
                            core_rdata      <= mem_we ? 32'h0 : mem_rdata;
                            core_err        <= 1'b0;
                            core_err_cause  <= CauseNone;
                            state_q         <= RESP;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_rvalid) begin
                        core_resp_valid <= 1'b1;
                        core_rdata      <= mem_we ? 32'h0 : mem_rdata;
                        core_err        <= 1'b0;
                        core_err_cause  <= CauseNone;
                        state_q         <= RESP;
                    end else if (cnt_q == CntLast) begin
                        core_resp_valid <= 1'b1;
                        core_rdata      <= 32'h0;
                        core_err        <= 1'b1;
                        core_err_cause  <= CauseTmo;
                        state_q         <= RESP;
                    end
                end
                RESP: begin
                    core_resp_valid <= 1'b0;
                    core_rdata      <= 32'h0;
                    core_err        <= 1'b0;
                    core_err_cause  <= CauseNone;
                    state_q         <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares them, including response cycle.
module tb_data_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_valid, core_req_ready, core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr, core_wdata;
    logic        core_resp_valid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic [1:0]  core_err_cause;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    data_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_we(core_we), .core_funct3(core_funct3), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_resp_valid(core_resp_valid),
        .core_rdata(core_rdata), .core_err(core_err), .core_err_cause(core_err_cause),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, req);
    endfunction

    function automatic void fail_now(input string nm);
        total++;
        $display("FAIL %s: bound expired", nm);
    endfunction

    // Monitor: every response pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (core_resp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_resp: got rdata %h err %b cause %b, want none",
                         core_rdata, core_err, core_err_cause);
            end else begin
                e = exp_q.pop_front();
                chk("resp_rdata", core_rdata, e.rdata);
                chk("resp_err", 32'(core_err), 32'(e.err));
                chk("resp_cause", 32'(core_err_cause), 32'(e.cause));
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (!core_req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!core_req_ready) fail_now("wait_ready");
    endtask

    task automatic check_bus(input logic we, input logic [31:0] ea, input logic [3:0] ebe,
                             input logic [31:0] ewd);
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("mem_addr", mem_addr, ea);
        chk("mem_be", 32'(mem_be), 32'(ebe));
        chk("mem_we", 32'(mem_we), 32'(we));
        chk("mem_wdata", mem_wdata, ewd);
    endtask

    // gd = REQ cycles before gnt; rd = 0 same-cycle rvalid, >0 WAIT cycle of rvalid, <0 never.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int gd, input int rd,
                         input logic [31:0] rdat, input logic mis, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] erd, input logic eerr,
                         input logic [1:0] ecause);
        exp_t e;
        int   acc;
        int   w;
        wait_ready();
        core_req_valid = 1'b1;
        core_we        = we;
        core_funct3    = f3;
        core_addr      = addr;
        core_wdata     = wd;
        acc     = cyc + 1;
        e.rdata = erd;
        e.err   = eerr;
        e.cause = ecause;
        e.cyc   = mis ? acc : ((rd < 0) ? acc + 1 + gd + TO : acc + 1 + gd + rd);
        exp_q.push_back(e);
        @(negedge clk);
        core_req_valid = 1'b0;
        if (mis) begin
            chk("no_mem_req", 32'(mem_req), 32'd0);
            @(negedge clk);
            chk("no_mem_req", 32'(mem_req), 32'd0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                check_bus(we, addr & 32'hFFFF_FFFC, ebe, ewd);
                if (i < gd) @(negedge clk);
            end
            mem_gnt = 1'b1;
            if (rd == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdat;
            end
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            chk("mem_req_drop", 32'(mem_req), 32'd0);
            if (rd > 0) begin
                repeat (rd - 1) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = rdat;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
        end
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            fail_now("resp_wait");
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        core_req_valid = 1'b0;
        core_we        = 1'b0;
        core_funct3    = 3'b000;
        core_addr      = 32'h0;
        core_wdata     = 32'h0;
        mem_gnt        = 1'b0;
        mem_rvalid     = 1'b0;
        mem_rdata      = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(core_req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_resp_valid", 32'(core_resp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW 0x100 -> DEADBEEF
        issue(1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,
              32'hDEADBEEF, 1'b0, 2'b00);
        // SB 0x203, read data on the bus must not leak into the store response
        issue(1'b1, 3'b000, 32'h203, 32'h0000_00A5, 0, 1, 32'h1234_5678, 1'b0, 4'b1000,
              32'hA5A5_A5A5, 32'h0, 1'b0, 2'b00);
        // SH 0x102
        issue(1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 0, 1, 32'h0, 1'b0, 4'b1100,
              32'hBEEF_BEEF, 32'h0, 1'b0, 2'b00);
        // SB 0x001 lane 1
        issue(1'b1, 3'b000, 32'h001, 32'h0000_003C, 0, 2, 32'h0, 1'b0, 4'b0010,
              32'h3C3C_3C3C, 32'h0, 1'b0, 2'b00);
        // LH 0x101 misaligned
        issue(1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0,
              32'h0, 1'b1, 2'b01);
        // SW 0x102 misaligned
        issue(1'b1, 3'b010, 32'h102, 32'h5555_5555, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0,
              32'h0, 1'b1, 2'b10);
        // Unsupported load funct3 011 and store funct3 100
        issue(1'b0, 3'b011, 32'h000, 32'h0, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0,
              32'h0, 1'b1, 2'b01);
        issue(1'b1, 3'b100, 32'h000, 32'h0, 0, 0, 32'h0, 1'b1, 4'b0, 32'h0,
              32'h0, 1'b1, 2'b10);
        // LBU 0x007, gnt and rvalid in the same cycle
        issue(1'b0, 3'b100, 32'h007, 32'h0, 0, 0, 32'h8899_AABB, 1'b0, 4'b1111, 32'h0,
              32'h8899_AABB, 1'b0, 2'b00);
        // LW 0x40 with gnt held low for 5 cycles
        issue(1'b0, 3'b010, 32'h040, 32'h0, 5, 1, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0,
              32'hCAFE_F00D, 1'b0, 2'b00);
        // Timeout, then a normal request, then rvalid on the last allowed cycle
        issue(1'b0, 3'b010, 32'h080, 32'h0, 0, -1, 32'h0, 1'b0, 4'b1111, 32'h0,
              32'h0, 1'b1, 2'b11);
        issue(1'b0, 3'b010, 32'h084, 32'h0, 0, 1, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0,
              32'h0BAD_F00D, 1'b0, 2'b00);
        issue(1'b0, 3'b010, 32'h088, 32'h0, 0, TO, 32'h1357_9BDF, 1'b0, 4'b1111, 32'h0,
              32'h1357_9BDF, 1'b0, 2'b00);

        // Reset asserted during WAIT abandons the transaction
        wait_ready();
        core_req_valid = 1'b1;
        core_we        = 1'b1;
        core_funct3    = 3'b010;
        core_addr      = 32'h300;
        core_wdata     = 32'hFFFF_FFFF;
        @(negedge clk);
        core_req_valid = 1'b0;
        mem_gnt        = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_mem_be", 32'(mem_be), 32'd0);
        chk("arst_mem_we", 32'(mem_we), 32'd0);
        chk("arst_mem_wdata", mem_wdata, 32'h0);
        chk("arst_ready", 32'(core_req_ready), 32'd1);
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_gnt    = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        chk("stray_ignored_ready", 32'(core_req_ready), 32'd1);
        issue(1'b0, 3'b010, 32'h304, 32'h0, 0, 1, 32'h2468_ACE0, 1'b0, 4'b1111, 32'h0,
              32'h2468_ACE0, 1'b0, 2'b00);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Sequential data-memory access controller between the core's execute/memory stage and the data memory bus.
- Accepts one load or store request per handshake from the core.
- Computes the byte-enable mask and lane-shifted store data, and flags misaligned accesses.
- Drives a req/gnt/rvalid memory bus with one outstanding transaction, returning the raw 32-bit read word.
- The returned word feeds the load extraction/extension logic downstream; the core stalls while core_req_ready is low.

Parameters:
- TIMEOUT_CYCLES, 255, cycles allowed in WAIT for mem_rvalid before aborting with a bus error; must be ≥ 1.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- core_req_valid  input  1  core presents a memory request.
- core_req_ready  output  1  controller accepts the request this cycle.
- core_we  input  1  1 = store, 0 = load.
- core_funct3  input  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
- core_addr  input  32  byte address (rs1 + immediate).
- core_wdata  input  32  store data (rs2), unshifted.
- core_resp_valid  output  1  single-cycle pulse: transaction complete.
- core_rdata  output  32  raw aligned memory word for loads; 0 for stores and errors.
- core_err  output  1  qualified by core_resp_valid: access failed.
- core_err_cause  output  2  00 none, 01 load misaligned, 10 store misaligned, 11 bus timeout.
- mem_req  output  1  bus request.
- mem_gnt  input  1  bus accepts the request.
- mem_addr  output  32  word address, which is {core_addr[31:2], 2'b00}.
- mem_we  output  1  write enable.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-shifted store data.
- mem_rvalid  input  1  response valid; for writes it acknowledges completion.
- mem_rdata  input  32  read data.

Behaviour:
Reset (asynchronous, rst_n low):
- State = IDLE.
- Outputs: mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, core_resp_valid = 0, core_rdata = 0, core_err = 0, core_err_cause = 00, timeout counter = 0.
- core_req_ready = 1 combinationally in IDLE.
- Reset mid-transaction abandons the transaction; no response is produced.

FSM states: IDLE, REQ, WAIT, RESP.

IDLE:
- core_req_ready = 1.
- On core_req_valid, register addr, we, funct3, wdata, be, and the misalign flag.
- Misaligned means: halfword with addr[0] = 1, or word with addr[1:0] ≠ 00.
- Unsupported funct3 (011, 110, 111, or 1xx on a store) is treated as misaligned.
- If misaligned, go to RESP with the error and cause 01 (load) or 10 (store); the memory bus is never touched.
- Otherwise go to REQ.

Byte enables and store data:
- Byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
- Half: be = 0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
- Word: be = 1111; wdata unchanged.
- Loads drive be = 1111.

REQ:
- mem_req = 1; mem_addr, mem_we, mem_be, and mem_wdata are stable while mem_req = 1 until mem_gnt.
- On mem_gnt, go to WAIT, clear the counter, and drop mem_req in the next cycle.
- mem_rvalid in the same cycle as mem_gnt is legal; handle it as if it arrived in WAIT and go directly to RESP.

WAIT:
- Increment the counter each cycle.
- On mem_rvalid, latch mem_rdata for loads (or 0 for stores) and go to RESP with no error.
- If the counter reaches TIMEOUT_CYCLES without mem_rvalid, go to RESP with err = 1 and cause 11.
- mem_rvalid arriving in the same cycle as the timeout takes priority (success).

RESP:
- core_resp_valid = 1 for exactly one cycle, then return to IDLE.
- core_req_ready = 0 in RESP; no back-to-back acceptance.
- Minimum latency: request accepted at cycle N → response at N+3 with zero-wait gnt/rvalid.
- Misaligned access: response at N+1.

Other rules:
- core_req_ready = 0 in REQ, WAIT, and RESP.
- mem_rvalid or mem_gnt outside the expected states is ignored.

Test Plan:
1. LW, addr 0x100, gnt and rvalid one cycle after each request, mem_rdata = 0xDEADBEEF → mem_addr = 0x100, mem_be = 1111, mem_we = 0; core_resp_valid pulse with core_rdata = 0xDEADBEEF, err = 0.
2. SB, addr 0x203, core_wdata = 0x000000A5 → mem_addr = 0x200, mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_we = 1; response with core_rdata = 0.
3. SH, addr 0x102 → mem_be = 1100, mem_wdata = {2{wdata[15:0]}}. LH at 0x101 → no mem_req ever asserted; response at the next cycle with err = 1, cause 01. SW at 0x102 → cause 10.
4. mem_gnt held low for 5 cycles → mem_req and all bus outputs stable for the 5 cycles; completion after gnt/rvalid.
5. TIMEOUT_CYCLES = 4, gnt given, rvalid never → response after 4 WAIT cycles with err = 1, cause 11; a second request is then accepted in IDLE. Variant: rvalid arriving on the 4th cycle → success.
6. rst_n pulsed low during WAIT → all outputs 0 immediately, state IDLE; a following LW completes normally.
